// File: rtl/wave_request_sched_pkg.sv
// rtl/wave_request_sched_pkg.sv - shared constants and FSM encoding for the wave request scheduler
package wave_request_sched_pkg;

  localparam logic [4:0] FREQ_NONE = 5'd31;
  localparam logic [4:0] FREQ_MAX  = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SETTLE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/vsync_edge.sv
// rtl/vsync_edge.sv - two-flop synchroniser plus registered falling-edge detect (3-clock latency)
module vsync_edge (
  input  logic clock,
  input  logic reset,
  input  logic vsync,
  output logic fall
);

  logic sync_a;
  logic sync_b;
  logic sync_d;

  // Flops reset high: vsync idles high, so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      sync_d <= 1'b1;
      fall   <= 1'b0;
    end else begin
      sync_a <= vsync;
      sync_b <= sync_a;
      sync_d <= sync_b;
      fall   <= sync_d & ~sync_b;
    end
  end

endmodule

// File: rtl/wave_request_sched.sv
// rtl/wave_request_sched.sv - buffers keyboard frequency requests and paces bank swaps into physics
module wave_request_sched
  import wave_request_sched_pkg::*;
#(
  parameter int          PULSE_CYCLES   = 2,
  parameter int          MIN_FRAMES     = 4,
  parameter int          TIMEOUT_FRAMES = 30,
  parameter logic [10:0] SPEED          = 11'd2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        req_valid,
  input  logic [4:0]  req_id1,
  input  logic [4:0]  req_id2,
  input  logic        game_start,
  input  logic        pause,
  input  logic        curr_w0,
  input  logic [3:0]  wave_ready,
  output logic [4:0]  freq_id1,
  output logic [4:0]  freq_id2,
  output logic        new_f_in,
  output logic        r_offset,
  output logic [10:0] d_offset,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  drop_cnt
);

  localparam int FW = $clog2(TIMEOUT_FRAMES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  sched_state_t   state;
  logic           vs_fall;
  logic           pend_valid;
  logic [4:0]     pend_id1;
  logic [4:0]     pend_id2;
  logic [4:0]     last_id1;
  logic [4:0]     last_id2;
  logic           tgt_hi;
  logic           w0_at_issue;
  logic [PW-1:0]  pulse_cnt;
  logic [FW-1:0]  frame_cnt;
  logic           pulse_q;
  logic           armed;

  logic           req_dup;
  logic           issue_now;
  logic [4:0]     issue_id1;
  logic [4:0]     issue_id2;
  logic [1:0]     ready_pair;
  logic           swap_done;
  logic           abort;
  logic           r_offset_nxt;

  vsync_edge u_vsync_edge (
    .clock (clock),
    .reset (reset),
    .vsync (vsync),
    .fall  (vs_fall)
  );

  assign req_dup    = req_valid && !pend_valid && (req_id1 == last_id1) && (req_id2 == last_id2);
  assign issue_now  = (state == ST_IDLE) && (pend_valid || (req_valid && !req_dup));
  assign issue_id1  = pend_valid ? pend_id1 : req_id1;
  assign issue_id2  = pend_valid ? pend_id2 : req_id2;
  assign ready_pair = tgt_hi ? wave_ready[3:2] : wave_ready[1:0];
  // The swap is only real once physics has flipped its active bank away from the issue-time one.
  assign swap_done  = (&ready_pair) && (curr_w0 != w0_at_issue);
  assign abort      = game_start && ((state == ST_ISSUE) || (state == ST_WAIT));
  assign new_f_in   = pulse_q && !reset && !abort;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    r_offset_nxt = r_offset;
    if (vs_fall) begin
      if (r_offset)   r_offset_nxt = 1'b0;
      else if (armed) r_offset_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      freq_id1    <= FREQ_NONE;
      freq_id2    <= FREQ_NONE;
      last_id1    <= FREQ_NONE;
      last_id2    <= FREQ_NONE;
      pend_valid  <= 1'b0;
      pend_id1    <= FREQ_NONE;
      pend_id2    <= FREQ_NONE;
      tgt_hi      <= 1'b0;
      w0_at_issue <= 1'b0;
      pulse_cnt   <= '0;
      frame_cnt   <= '0;
      pulse_q     <= 1'b0;
      armed       <= 1'b0;
      r_offset    <= 1'b0;
      d_offset    <= 11'd0;
      timeout_err <= 1'b0;
      drop_cnt    <= 8'd0;
    end else begin
      r_offset <= r_offset_nxt;
      if (vs_fall && !r_offset && armed) armed <= 1'b0;
      if (game_start) armed <= 1'b1;
      if (vs_fall) d_offset <= (!pause && !r_offset_nxt) ? SPEED : 11'd0;

      // In IDLE the pending slot drains this cycle, so a new request refills it without a drop.
      if (state == ST_IDLE) begin
        if (pend_valid) begin
          pend_valid <= req_valid;
          pend_id1   <= req_id1;
          pend_id2   <= req_id2;
        end
      end else if (req_valid && !req_dup) begin
        if (pend_valid && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        pend_valid <= 1'b1;
        pend_id1   <= req_id1;
        pend_id2   <= req_id2;
      end

      case (state)
        ST_IDLE: begin
          if (issue_now) begin
            freq_id1    <= issue_id1;
            freq_id2    <= issue_id2;
            tgt_hi      <= curr_w0;
            w0_at_issue <= curr_w0;
            pulse_cnt   <= '0;
            pulse_q     <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
            pulse_q   <= 1'b0;
            frame_cnt <= '0;
            state     <= ST_WAIT;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (swap_done) begin
            frame_cnt <= '0;
            state     <= ST_SETTLE;
          end else if (vs_fall) begin
            if (frame_cnt == FW'(TIMEOUT_FRAMES - 1)) begin
              timeout_err <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (vs_fall) begin
            if (frame_cnt == FW'(MIN_FRAMES - 1)) begin
              last_id1 <= freq_id1;
              last_id2 <= freq_id2;
              state    <= ST_IDLE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (abort) begin
        state   <= ST_IDLE;
        pulse_q <= 1'b0;
      end
      if (game_start) timeout_err <= 1'b0;
    end
  end

endmodule
